// File: rtl/song_player.sv
// -----------------------------------------------------------------------------
// song_player
//   Autoplay note source for the piano. Walks through built-in song ROMs and
//   produces the same 4-bit note code and 7-bit one-hot LED pattern as the
//   keyboard controller, so the top level can mux the two sources.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   mode         in   3  mode switches; playback enabled when equal to AUTO_MODE
//   song_select  in   2  raw buttons, bit0 = next song, bit1 = previous song
//   note_out     out  4  0 = rest, 1..7 = do..si, 8..14 = one octave up
//   led_out      out  7  one-hot scale degree of note_out
//   song_idx     out  2  currently selected song
//   playing      out  1  high while loading, playing or in the inter-note gap
//   done         out  1  high once the end marker of the song was reached
//
// Notes
//   ROM entries are {note[3:0], dur[2:0]}; dur 0 plays as 1, note 15 ends the
//   song. One note period is dur*BEAT_CYCLES + 1 cycles: one LOAD cycle, the
//   audible part, then GAP_CYCLES of silence. GAP_CYCLES must be at least 1
//   and below BEAT_CYCLES.
// -----------------------------------------------------------------------------
module song_player #(
    parameter int         BEAT_CYCLES = 25_000_000,
    parameter int         GAP_CYCLES  = 2_500_000,
    parameter int         NUM_SONGS   = 3,
    parameter int         MAX_LEN     = 64,
    parameter logic [2:0] AUTO_MODE   = 3'd1,
    parameter bit         LOOP        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic [1:0] song_select,
    output logic [3:0] note_out,
    output logic [6:0] led_out,
    output logic [1:0] song_idx,
    output logic       playing,
    output logic       done
);

    localparam int STEP_W = $clog2(MAX_LEN + 1);
    // The longest single phase is a full 7-beat note.
    localparam int CNT_W  = $clog2(7 * BEAT_CYCLES + 1);

    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_END  = STEP_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  BEAT_LEN  = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_LEN   = CNT_W'(GAP_CYCLES);
    localparam logic [1:0]        LAST_SONG = 2'(NUM_SONGS - 1);
    localparam logic [3:0]        NOTE_END  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Song ROM; any index past the listed entries reads as the end marker.
    function automatic logic [6:0] rom_entry(input logic [1:0] song, input logic [31:0] idx);
        logic [6:0] e;
        e = {NOTE_END, 3'd0};
        case (song)
            2'd0: begin
                case (idx)
                    32'd0:   e = {4'd1, 3'd1};
                    32'd1:   e = {4'd3, 3'd2};
                    32'd2:   e = {4'd5, 3'd1};
                    32'd3:   e = {4'd0, 3'd1};
                    default: e = {NOTE_END, 3'd0};
                endcase
            end
            2'd1: begin
                case (idx)
                    32'd0:   e = {4'd8,  3'd1};
                    32'd1:   e = {4'd10, 3'd2};
                    32'd2:   e = {4'd12, 3'd0};
                    32'd3:   e = {4'd14, 3'd1};
                    default: e = {NOTE_END, 3'd0};
                endcase
            end
            2'd2: begin
                case (idx)
                    32'd0:   e = {4'd7, 3'd3};
                    32'd1:   e = {4'd6, 3'd1};
                    32'd2:   e = {4'd0, 3'd2};
                    32'd3:   e = {4'd2, 3'd1};
                    default: e = {NOTE_END, 3'd0};
                endcase
            end
            2'd3: begin
                case (idx)
                    32'd0:   e = {4'd3, 3'd1};
                    32'd1:   e = {4'd0, 3'd1};
                    32'd2:   e = {4'd3, 3'd1};
                    default: e = {NOTE_END, 3'd0};
                endcase
            end
            default: e = {NOTE_END, 3'd0};
        endcase
        return e;
    endfunction

    // One-hot scale degree; both octaves light the same LED.
    function automatic logic [6:0] led_of(input logic [3:0] n);
        logic [6:0] l;
        l = 7'd0;
        if ((n >= 4'd1) && (n <= 4'd7)) begin
            l = 7'd1 << (n - 4'd1);
        end else if ((n >= 4'd8) && (n <= 4'd14)) begin
            l = 7'd1 << (n - 4'd8);
        end else begin
            l = 7'd0;
        end
        return l;
    endfunction

    logic [2:0]        mode_s1_r, mode_s2_r;
    logic [1:0]        sel_s1_r, sel_s2_r, sel_d_r;
    state_t            state_r, state_nxt_s;
    logic [STEP_W-1:0] step_r, step_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [3:0]        note_nxt_s;
    logic [6:0]        led_nxt_s;
    logic [1:0]        song_nxt_s;
    logic              playing_nxt_s, done_nxt_s;
    logic              auto_s, next_s, prev_s, change_s;
    logic [1:0]        sel_pulse_s;
    logic [6:0]        entry_s;
    logic [3:0]        rom_note_s;
    logic [2:0]        rom_dur_s;

    // Two-flop synchronisers for the switches and buttons, plus the button edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s1_r <= 3'd0;
            mode_s2_r <= 3'd0;
            sel_s1_r  <= 2'd0;
            sel_s2_r  <= 2'd0;
            sel_d_r   <= 2'd0;
        end else begin
            mode_s1_r <= mode;
            mode_s2_r <= mode_s1_r;
            sel_s1_r  <= song_select;
            sel_s2_r  <= sel_s1_r;
            sel_d_r   <= sel_s2_r;
        end
    end

    // Button pulses and song index stepping; simultaneous next+prev cancel out.
    always_comb begin
        auto_s      = (mode_s2_r == AUTO_MODE);
        sel_pulse_s = sel_s2_r & ~sel_d_r;
        next_s      = (sel_pulse_s == 2'b01);
        prev_s      = (sel_pulse_s == 2'b10);
        change_s    = next_s | prev_s;
        if (next_s) begin
            song_nxt_s = (song_idx == LAST_SONG) ? 2'd0 : (song_idx + 2'd1);
        end else if (prev_s) begin
            song_nxt_s = (song_idx == 2'd0) ? LAST_SONG : (song_idx - 2'd1);
        end else begin
            song_nxt_s = song_idx;
        end
    end

    // Playback sequencer next-state and next-output logic.
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        cnt_nxt_s   = cnt_r;
        note_nxt_s  = note_out;
        led_nxt_s   = led_out;
        entry_s     = rom_entry(song_idx, 32'(step_r));
        rom_note_s  = entry_s[6:3];
        rom_dur_s   = (entry_s[2:0] == 3'd0) ? 3'd1 : entry_s[2:0];

        if (!auto_s) begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = STEP_ZERO;
            cnt_nxt_s   = CNT_ZERO;
            note_nxt_s  = 4'd0;
            led_nxt_s   = 7'd0;
        end else if (change_s && (state_r != ST_IDLE)) begin
            // Truncate whatever is sounding and restart the new song.
            state_nxt_s = ST_LOAD;
            step_nxt_s  = STEP_ZERO;
            cnt_nxt_s   = CNT_ZERO;
            note_nxt_s  = 4'd0;
            led_nxt_s   = 7'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_LOAD;
                    step_nxt_s  = STEP_ZERO;
                    note_nxt_s  = 4'd0;
                    led_nxt_s   = 7'd0;
                end
                ST_LOAD: begin
                    if ((rom_note_s == NOTE_END) || (step_r == STEP_END)) begin
                        state_nxt_s = ST_DONE;
                        note_nxt_s  = 4'd0;
                        led_nxt_s   = 7'd0;
                    end else begin
                        state_nxt_s = ST_PLAY;
                        note_nxt_s  = rom_note_s;
                        led_nxt_s   = led_of(rom_note_s);
                        // Counts down to zero, so load the audible length minus one.
                        cnt_nxt_s   = CNT_W'(rom_dur_s) * BEAT_LEN - GAP_LEN - CNT_ONE;
                    end
                end
                ST_PLAY: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_nxt_s = ST_GAP;
                        note_nxt_s  = 4'd0;
                        led_nxt_s   = 7'd0;
                        cnt_nxt_s   = GAP_LEN - CNT_ONE;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_nxt_s = ST_LOAD;
                        step_nxt_s  = step_r + STEP_ONE;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    note_nxt_s = 4'd0;
                    led_nxt_s  = 7'd0;
                    if (LOOP) begin
                        state_nxt_s = ST_LOAD;
                        step_nxt_s  = STEP_ZERO;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    step_nxt_s  = STEP_ZERO;
                    cnt_nxt_s   = CNT_ZERO;
                    note_nxt_s  = 4'd0;
                    led_nxt_s   = 7'd0;
                end
            endcase
        end

        playing_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_PLAY) ||
                        (state_nxt_s == ST_GAP);
        done_nxt_s    = (state_nxt_s == ST_DONE);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            step_r   <= STEP_ZERO;
            cnt_r    <= CNT_ZERO;
            note_out <= 4'd0;
            led_out  <= 7'd0;
            song_idx <= 2'd0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            step_r   <= step_nxt_s;
            cnt_r    <= cnt_nxt_s;
            note_out <= note_nxt_s;
            led_out  <= led_nxt_s;
            song_idx <= song_nxt_s;
            playing  <= playing_nxt_s;
            done     <= done_nxt_s;
        end
    end

endmodule

// File: doc/song_player.md
Name: song_player

Overview:
- Autoplay note source for the piano. Steps through built-in song ROMs and emits the same 4-bit note code and 7-bit LED pattern that the keyboard controller produces.
- Its note_out drives the buzzer whenever mode selects autoplay. The top level muxes note_out and led_out against the keyboard controller.
- song_select[0] pulses step to the next song; song_select[1] pulses step to the previous song.

Parameters:
- BEAT_CYCLES, 25_000_000, clock cycles per beat unit.
- GAP_CYCLES, 2_500_000, silent cycles at the tail of each note. Must be less than BEAT_CYCLES.
- NUM_SONGS, 3, number of songs in ROM. Range 1..4.
- MAX_LEN, 64, maximum entries per song.
- AUTO_MODE, 3'd1, mode value that enables playback.
- LOOP, 0, 1 = restart the song after its end marker.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mode  in  3  mode switches; playback enabled when equal to AUTO_MODE
- song_select  in  2  bit0 = next, bit1 = prev; raw buttons
- note_out  out  4  0 = rest, 1..7 = do..si, 8..14 = same notes one octave up
- led_out  out  7  one-hot scale degree of note_out
- song_idx  out  2  currently selected song
- playing  out  1  high in LOAD, PLAY or GAP
- done  out  1  high in DONE

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, song_idx 0, step 0, synchronisers cleared.
- Synchronisation: mode and song_select each pass through 2-flop synchronisers. Buttons are rising-edge detected on the synchronised value, giving a 1-cycle pulse.
- ROM entry is 7 bits: {note[3:0], dur[2:0]}.
  - dur 0 is treated as 1.
  - note 15 is the end marker.
- Song 0 contents are fixed: (1,1), (3,2), (5,1), (0,1), (15,x). Songs 1..2 are free.
- auto = synchronised mode equals AUTO_MODE.
- State IDLE:
  - note_out 0. Go to LOAD with step = 0 when auto is high.
  - The transition happens on the 3rd rising edge after mode changes. Note data is valid after the 4th edge.
- State LOAD (1 cycle):
  - Fetch ROM[song_idx][step].
  - If note is 15, or step equals MAX_LEN, go to DONE.
  - Otherwise latch note_out and led_out, load the counter, go to PLAY.
- State PLAY:
  - Hold note_out for dur*BEAT_CYCLES − GAP_CYCLES cycles, then go to GAP.
- State GAP:
  - note_out 0 and led_out 0 for GAP_CYCLES cycles.
  - Then step+1 and go to LOAD. One note period is dur*BEAT_CYCLES + 1 cycles.
- State DONE:
  - note_out 0, done 1.
  - If LOOP = 1, go to LOAD with step = 0 on the next cycle. Otherwise stay in DONE.
- led_out mapping:
  - note n in 1..7 gives led_out[n−1] = 1.
  - note n in 8..14 gives led_out[n−8] = 1.
  - note 0 gives led_out 0.
- Leaving auto mode: from any state, go to IDLE on the cycle auto falls. note_out, led_out, playing and done clear the same edge.
- Next pulse: song_idx = (song_idx+1) mod NUM_SONGS.
- Prev pulse: song_idx = song_idx−1, with 0 wrapping to NUM_SONGS−1.
- Both button pulses in the same cycle: ignored.
- Song change while auto is high, in any non-IDLE state: step = 0, go to LOAD next cycle. In-progress note is truncated; note_out is forced 0 during that LOAD.
- Song change in IDLE: only song_idx updates.
- Held button: one change per press, because detection is edge-based.
- Counters are sized for 7*BEAT_CYCLES. No overflow is permitted.

Test Plan:
Use BEAT_CYCLES=10, GAP_CYCLES=2, LOOP=0 unless stated.
- Reset mid-PLAY: assert rst during song 0 note 1 -> all outputs 0 immediately, without waiting for a clock edge. Deassert with auto held -> replay starts from step 0.
- Song 0 timing: mode=1 from IDLE -> note_out=1 and led_out=7'b0000001 after edge 4.
  - note_out 1 for 8 cycles, then 0 for 2 cycles.
  - LOAD, then note 3 (led bit2) for 18 cycles, gap 2.
  - Note 5 (led bit4) for 8 cycles, gap 2.
  - Rest for 10 cycles.
  - Then DONE: done=1, playing=0.
- LOOP=1: after the song 0 end marker -> DONE for 1 cycle, then note_out=1 again. Period is repeatable.
- Song wrap:
  - Prev pulse from song_idx 0 -> 2.
  - Next from 2 -> 0.
  - Simultaneous next+prev -> unchanged.
  - 1 ms held button -> one increment only.
- Song change during PLAY: next pulse mid-note -> note_out 0 in LOAD, then song 1 entry 0 plays from step 0.
- Mode exit: mode changes 1 -> 0 during PLAY -> note_out=0, led_out=0, playing=0 on the edge auto falls, 3rd edge after the change. Re-entering auto restarts at step 0.
